rgb_stat_regs: RTL and testbench

Local-bus register bank and per-frame RGB statistics engine for the rgb_analyze IP. It sits directly downstream of the AXI-Lite slave bridge: it consumes that bridge's write strobe/address/data and read request/address, and returns one-cycle-latency read data with a valid pulse. It accumulates per-frame pixel count, channel sums, and channel minima/maxima from a pixel stream in the same clock domain, then exposes committed results as read-only registers.

---
 rtl/rgb_analyze_pkg.sv | 56 +++++
 rtl/rgb_stat_regs_if.sv | 18 +
 rtl/rgb_stat_accum.sv | 132 +++++++++++++
 rtl/rgb_stat_regs.sv | 132 +++++++++++++
 tb/tb_rgb_stat_regs.sv | 232 +++++++++++++++++++++++
 5 files changed

// File: rtl/rgb_analyze_pkg.sv
// Shared definitions for the rgb_analyze register bank and statistics engine:
// register map, control/status bit positions, MIN/MAX packing and FSM encoding.
package rgb_analyze_pkg;

  localparam int unsigned FIELD_W = 10;

  localparam logic [7:0] OFS_CTRL      = 8'h00;
  localparam logic [7:0] OFS_STATUS    = 8'h04;
  localparam logic [7:0] OFS_FRAME_CNT = 8'h08;
  localparam logic [7:0] OFS_PIX_CNT   = 8'h0C;
  localparam logic [7:0] OFS_SUM_R     = 8'h10;
  localparam logic [7:0] OFS_SUM_G     = 8'h14;
  localparam logic [7:0] OFS_SUM_B     = 8'h18;
  localparam logic [7:0] OFS_MIN       = 8'h1C;
  localparam logic [7:0] OFS_MAX       = 8'h20;
  localparam logic [7:0] OFS_SCRATCH   = 8'h24;
  localparam logic [7:0] OFS_ID        = 8'h28;

  localparam int unsigned CTRL_EN_BIT      = 0;
  localparam int unsigned CTRL_ONESHOT_BIT = 1;
  localparam int unsigned STAT_DONE_BIT    = 0;
  localparam int unsigned STAT_BUSY_BIT    = 1;

  localparam logic [31:0] P_ID_DEFAULT = 32'h5247_4201;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_RUN   = 2'd2
  } stat_state_e;

  // Committed per-frame results as seen by the register bank.
  typedef struct packed {
    logic [31:0] frame_cnt;
    logic [31:0] pix_cnt;
    logic [31:0] sum_r;
    logic [31:0] sum_g;
    logic [31:0] sum_b;
    logic [31:0] min_pk;
    logic [31:0] max_pk;
  } stat_regs_t;

  function automatic logic [31:0] pack_rgb(input logic [FIELD_W-1:0] r,
                                           input logic [FIELD_W-1:0] g,
                                           input logic [FIELD_W-1:0] b);
    return {2'b00, b, g, r};
  endfunction

  // Accumulators stick at all-ones instead of wrapping.
  function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b);
    logic [32:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[32] ? 32'hFFFF_FFFF : s[31:0];
  endfunction

endpackage

// File: rtl/rgb_stat_regs_if.sv
// Local-bus bundle between the AXI-Lite bridge (master) and the register bank (slave).
interface rgb_stat_regs_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);
  logic              rx_dval;
  logic [ADDR_W-1:0] rx_addr;
  logic [DATA_W-1:0] rx_data;
  logic              tx_req;
  logic [ADDR_W-1:0] tx_addr;
  logic [DATA_W-1:0] tx_data;
  logic              tx_dval;

  modport master (output rx_dval, rx_addr, rx_data, tx_req, tx_addr,
                  input  tx_data, tx_dval);
  modport slave  (input  rx_dval, rx_addr, rx_data, tx_req, tx_addr,
                  output tx_data, tx_dval);
endinterface

// File: rtl/rgb_stat_accum.sv
// Frame statistics engine: vs-edge driven FSM, per-frame accumulators and the
// committed result registers exposed to the register bank.
module rgb_stat_accum
  import rgb_analyze_pkg::*;
#(
  parameter int unsigned P_PIX_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en_i,
  input  logic               oneshot_i,
  input  logic               vs_i,
  input  logic               de_i,
  input  logic [P_PIX_W-1:0] r_i,
  input  logic [P_PIX_W-1:0] g_i,
  input  logic [P_PIX_W-1:0] b_i,
  output logic               commit_c,
  output logic               busy_c,
  output stat_regs_t         stat_o
);

  stat_state_e state_q, state_d;
  logic        vs_q;
  logic        vs_edge;
  logic        clear_acc;
  logic        add_pix;
  logic [31:0] pix_cnt_q, pix_cnt_d;
  logic [31:0] sum_r_q, sum_r_d;
  logic [31:0] sum_g_q, sum_g_d;
  logic [31:0] sum_b_q, sum_b_d;
  logic [2:0][P_PIX_W-1:0] min_q, min_d;
  logic [2:0][P_PIX_W-1:0] max_q, max_d;
  logic [2:0][P_PIX_W-1:0] pix;
  stat_regs_t  stat_q, stat_d;

  assign vs_edge = vs_i & ~vs_q;
  assign pix     = {b_i, g_i, r_i};
  assign busy_c  = (state_q == ST_RUN);
  assign stat_o  = stat_q;

  always_comb begin
    state_d   = state_q;
    pix_cnt_d = pix_cnt_q;
    sum_r_d   = sum_r_q;
    sum_g_d   = sum_g_q;
    sum_b_d   = sum_b_q;
    min_d     = min_q;
    max_d     = max_q;
    stat_d    = stat_q;
    commit_c  = 1'b0;
    clear_acc = 1'b0;
    add_pix   = 1'b0;

    // Disable takes priority over any frame edge; the edge-cycle pixel is dropped.
    case (state_q)
      ST_IDLE:  if (en_i) state_d = ST_ARMED;
      ST_ARMED: begin
        if (!en_i) state_d = ST_IDLE;
        else if (vs_edge) begin
          state_d   = ST_RUN;
          clear_acc = 1'b1;
        end
      end
      ST_RUN: begin
        if (!en_i) state_d = ST_IDLE;
        else if (vs_edge) begin
          commit_c  = 1'b1;
          clear_acc = !oneshot_i;
          if (oneshot_i) state_d = ST_IDLE;
        end else if (de_i) add_pix = 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase

    if (commit_c) begin
      stat_d.frame_cnt = stat_q.frame_cnt + 32'd1;
      stat_d.pix_cnt   = pix_cnt_q;
      stat_d.sum_r     = sum_r_q;
      stat_d.sum_g     = sum_g_q;
      stat_d.sum_b     = sum_b_q;
      stat_d.min_pk    = '0;
      stat_d.max_pk    = '0;
      if (pix_cnt_q != 32'd0) begin
        stat_d.min_pk = pack_rgb(FIELD_W'(min_q[0]), FIELD_W'(min_q[1]), FIELD_W'(min_q[2]));
        stat_d.max_pk = pack_rgb(FIELD_W'(max_q[0]), FIELD_W'(max_q[1]), FIELD_W'(max_q[2]));
      end
    end

    if (clear_acc) begin
      pix_cnt_d = '0;
      sum_r_d   = '0;
      sum_g_d   = '0;
      sum_b_d   = '0;
      min_d     = '1;
      max_d     = '0;
    end else if (add_pix) begin
      pix_cnt_d = sat_add(pix_cnt_q, 32'd1);
      sum_r_d   = sat_add(sum_r_q, 32'(r_i));
      sum_g_d   = sat_add(sum_g_q, 32'(g_i));
      sum_b_d   = sat_add(sum_b_q, 32'(b_i));
      for (int c = 0; c < 3; c++) begin
        if (pix[c] < min_q[c]) min_d[c] = pix[c];
        if (pix[c] > max_q[c]) max_d[c] = pix[c];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      vs_q      <= 1'b0;
      pix_cnt_q <= '0;
      sum_r_q   <= '0;
      sum_g_q   <= '0;
      sum_b_q   <= '0;
      min_q     <= '0;
      max_q     <= '0;
      stat_q    <= '0;
    end else begin
      state_q   <= state_d;
      vs_q      <= vs_i;
      pix_cnt_q <= pix_cnt_d;
      sum_r_q   <= sum_r_d;
      sum_g_q   <= sum_g_d;
      sum_b_q   <= sum_b_d;
      min_q     <= min_d;
      max_q     <= max_d;
      stat_q    <= stat_d;
    end
  end

endmodule

// File: rtl/rgb_stat_regs.sv
// Register bank for rgb_analyze: local-bus decode, CTRL/STATUS/SCRATCH and a
// registered one-cycle read path over the committed frame statistics.
module rgb_stat_regs
  import rgb_analyze_pkg::*;
#(
  parameter int unsigned C_S_AXI_DATA_WIDTH = 32,
  parameter int unsigned C_S_AXI_ADDR_WIDTH = 32,
  parameter int unsigned P_PIX_W            = 8,
  parameter logic [31:0] P_ID               = P_ID_DEFAULT
) (
  input  logic                          S_AXI_ACLK,
  input  logic                          S_AXI_ARESETN,
  input  logic                          i_rx_dval,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0] i_rx_addr,
  input  logic [C_S_AXI_DATA_WIDTH-1:0] i_rx_data,
  input  logic                          i_tx_req,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0] i_tx_addr,
  output logic [C_S_AXI_DATA_WIDTH-1:0] o_tx_data,
  output logic                          o_tx_dval,
  input  logic                          i_vs,
  input  logic                          i_de,
  input  logic [P_PIX_W-1:0]            i_r,
  input  logic [P_PIX_W-1:0]            i_g,
  input  logic [P_PIX_W-1:0]            i_b
);

  localparam int unsigned DW = C_S_AXI_DATA_WIDTH;

  logic          ctrl_en_q, ctrl_en_d;
  logic          ctrl_os_q, ctrl_os_d;
  logic          done_q, done_d;
  logic [DW-1:0] scratch_q, scratch_d;
  logic [DW-1:0] rd_data_q, rd_data_d;
  logic          rd_dval_q;
  logic [7:0]    wr_ofs, rd_ofs;
  logic          wr_ctrl, wr_status, wr_scratch;
  logic [DW-1:0] ctrl_word, status_word;
  logic          commit_c, busy_c;
  stat_regs_t    stat;
  logic          unused_addr_bits;

  // Only byte-address bits [7:2] select a register; the rest alias.
  assign wr_ofs           = {i_rx_addr[7:2], 2'b00};
  assign rd_ofs           = {i_tx_addr[7:2], 2'b00};
  assign unused_addr_bits = ^{i_rx_addr[C_S_AXI_ADDR_WIDTH-1:8], i_rx_addr[1:0],
                              i_tx_addr[C_S_AXI_ADDR_WIDTH-1:8], i_tx_addr[1:0]};
  assign wr_ctrl          = i_rx_dval && (wr_ofs == OFS_CTRL);
  assign wr_status        = i_rx_dval && (wr_ofs == OFS_STATUS);
  assign wr_scratch       = i_rx_dval && (wr_ofs == OFS_SCRATCH);

  rgb_stat_accum #(.P_PIX_W(P_PIX_W)) u_accum (
    .clk       (S_AXI_ACLK),
    .rst_n     (S_AXI_ARESETN),
    .en_i      (ctrl_en_q),
    .oneshot_i (ctrl_os_q),
    .vs_i      (i_vs),
    .de_i      (i_de),
    .r_i       (i_r),
    .g_i       (i_g),
    .b_i       (i_b),
    .commit_c  (commit_c),
    .busy_c    (busy_c),
    .stat_o    (stat)
  );

  // A oneshot commit disarms CTRL unless a bus write lands in the same cycle.
  always_comb begin
    ctrl_en_d = ctrl_en_q;
    ctrl_os_d = ctrl_os_q;
    done_d    = done_q;
    scratch_d = scratch_q;
    if (commit_c && ctrl_os_q) begin
      ctrl_en_d = 1'b0;
      ctrl_os_d = 1'b0;
    end
    if (wr_ctrl) begin
      ctrl_en_d = i_rx_data[CTRL_EN_BIT];
      ctrl_os_d = i_rx_data[CTRL_ONESHOT_BIT];
    end
    if (wr_status && i_rx_data[STAT_DONE_BIT]) done_d = 1'b0;
    if (commit_c) done_d = 1'b1;
    if (wr_scratch) scratch_d = i_rx_data;
  end

  always_comb begin
    ctrl_word                     = '0;
    ctrl_word[CTRL_EN_BIT]        = ctrl_en_q;
    ctrl_word[CTRL_ONESHOT_BIT]   = ctrl_os_q;
    status_word                   = '0;
    status_word[STAT_DONE_BIT]    = done_q;
    status_word[STAT_BUSY_BIT]    = busy_c;
    rd_data_d                     = rd_data_q;
    if (i_tx_req) begin
      case (rd_ofs)
        OFS_CTRL:      rd_data_d = ctrl_word;
        OFS_STATUS:    rd_data_d = status_word;
        OFS_FRAME_CNT: rd_data_d = DW'(stat.frame_cnt);
        OFS_PIX_CNT:   rd_data_d = DW'(stat.pix_cnt);
        OFS_SUM_R:     rd_data_d = DW'(stat.sum_r);
        OFS_SUM_G:     rd_data_d = DW'(stat.sum_g);
        OFS_SUM_B:     rd_data_d = DW'(stat.sum_b);
        OFS_MIN:       rd_data_d = DW'(stat.min_pk);
        OFS_MAX:       rd_data_d = DW'(stat.max_pk);
        OFS_SCRATCH:   rd_data_d = scratch_q;
        OFS_ID:        rd_data_d = DW'(P_ID);
        default:       rd_data_d = '0;
      endcase
    end
  end

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      ctrl_en_q <= 1'b0;
      ctrl_os_q <= 1'b0;
      done_q    <= 1'b0;
      scratch_q <= '0;
      rd_data_q <= '0;
      rd_dval_q <= 1'b0;
    end else begin
      ctrl_en_q <= ctrl_en_d;
      ctrl_os_q <= ctrl_os_d;
      done_q    <= done_d;
      scratch_q <= scratch_d;
      rd_data_q <= rd_data_d;
      rd_dval_q <= i_tx_req;
    end
  end

  assign o_tx_data = rd_data_q;
  assign o_tx_dval = rd_dval_q;

endmodule

// File: tb/tb_rgb_stat_regs.sv
// Directed bench for rgb_stat_regs; reads queue their expected value, and a
// monitor pops and checks each returned word plus the one-cycle read latency.
module tb_rgb_stat_regs;

  localparam logic [31:0] A_CTRL = 32'h00, A_STATUS = 32'h04, A_FRAME = 32'h08,
                          A_PIX = 32'h0C, A_SUMR = 32'h10, A_SUMG = 32'h14,
                          A_SUMB = 32'h18, A_MIN = 32'h1C, A_MAX = 32'h20,
                          A_SCR = 32'h24, A_ID = 32'h28;

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       vs = 1'b0, de = 1'b0;
  logic [7:0] r = '0, g = '0, b = '0;
  int         n_cmp = 0;
  int         n_mis = 0;
  exp_t       exp_q[$];
  exp_t       e;
  logic       mon_req;

  rgb_stat_regs_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  rgb_stat_regs #(.C_S_AXI_DATA_WIDTH(32), .C_S_AXI_ADDR_WIDTH(32),
                  .P_PIX_W(8), .P_ID(32'h5247_4201)) dut (
    .S_AXI_ACLK(clk), .S_AXI_ARESETN(rst_n),
    .i_rx_dval(bus.rx_dval), .i_rx_addr(bus.rx_addr), .i_rx_data(bus.rx_data),
    .i_tx_req(bus.tx_req), .i_tx_addr(bus.tx_addr),
    .o_tx_data(bus.tx_data), .o_tx_dval(bus.tx_dval),
    .i_vs(vs), .i_de(de), .i_r(r), .i_g(g), .i_b(b)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] pk(input int unsigned pr, input int unsigned pg,
                                     input int unsigned pb);
    return {2'b00, 10'(pb), 10'(pg), 10'(pr)};
  endfunction

  // Every request edge must be followed by exactly one dval cycle.
  always @(posedge clk) begin
    mon_req = bus.tx_req;
    #1;
    if (mon_req || bus.tx_dval) begin
      n_cmp++;
      assert (bus.tx_dval === mon_req)
        else begin n_mis++; $error("FAIL tx_dval: observed %b expected %b", bus.tx_dval, mon_req); end
    end
    if (bus.tx_dval === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_cmp++; n_mis++;
        $error("FAIL unexpected_read: observed %h expected none", bus.tx_data);
      end else begin
        e = exp_q.pop_front();
        n_cmp++;
        assert (bus.tx_data === e.val)
          else begin n_mis++; $error("FAIL %s: observed %h expected %h", e.tag, bus.tx_data, e.val); end
      end
    end
  end

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    bus.rx_dval = 1'b1; bus.rx_addr = a; bus.rx_data = d;
    @(negedge clk);
    bus.rx_dval = 1'b0;
  endtask

  task automatic rd(input logic [31:0] a, input logic [31:0] x, input string tag);
    @(negedge clk);
    bus.tx_req = 1'b1; bus.tx_addr = a;
    exp_q.push_back('{tag, x});
    @(negedge clk);
    bus.tx_req = 1'b0;
  endtask

  task automatic pix(input logic [7:0] pr, input logic [7:0] pg, input logic [7:0] pb);
    @(negedge clk);
    de = 1'b1; r = pr; g = pg; b = pb;
    @(negedge clk);
    de = 1'b0;
  endtask

  task automatic vs_pulse();
    @(negedge clk);
    vs = 1'b1;
    @(negedge clk);
    vs = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    bus.rx_dval = 1'b0; bus.rx_addr = '0; bus.rx_data = '0;
    bus.tx_req = 1'b0; bus.tx_addr = '0;
    idle(3);
    rst_n = 1'b1;

    // Reset state and basic map
    rd(A_ID, 32'h5247_4201, "id");
    rd(A_SCR, 32'h0, "scratch_rst");
    rd(32'h3C, 32'h0, "unmapped_3c");
    rd(A_STATUS, 32'h0, "status_rst");
    wr(A_SCR, 32'hA5A5_5A5A);
    rd(A_SCR, 32'hA5A5_5A5A, "scratch_wr");
    wr(32'h30, 32'hFFFF_FFFF);
    rd(A_SCR, 32'hA5A5_5A5A, "scratch_after_30");
    rd(A_CTRL, 32'h0, "ctrl_after_30");
    rd(32'h30, 32'h0, "unmapped_30");

    // Oneshot frame
    wr(A_CTRL, 32'h3);
    idle(2);
    vs_pulse();
    pix(8'd10, 8'd5, 8'd255);
    pix(8'd20, 8'd5, 8'd255);
    pix(8'd30, 8'd5, 8'd255);
    pix(8'd40, 8'd5, 8'd255);
    vs_pulse();
    idle(1);
    rd(A_PIX, 32'd4, "os_pix");
    rd(A_SUMR, 32'd100, "os_sum_r");
    rd(A_SUMG, 32'd20, "os_sum_g");
    rd(A_SUMB, 32'd1020, "os_sum_b");
    rd(A_MIN, pk(10, 5, 255), "os_min");
    rd(A_MAX, pk(40, 5, 255), "os_max");
    rd(A_STATUS, 32'h1, "os_status");
    rd(A_FRAME, 32'd1, "os_frame");
    rd(A_CTRL, 32'h0, "os_ctrl");

    // Continuous mode
    wr(A_STATUS, 32'h1);
    wr(A_CTRL, 32'h1);
    idle(2);
    vs_pulse();
    pix(8'd1, 8'd2, 8'd3);
    pix(8'd4, 8'd5, 8'd6);
    vs_pulse();
    rd(A_PIX, 32'd2, "c1_pix");
    rd(A_SUMB, 32'd9, "c1_sum_b");
    wr(A_STATUS, 32'h1);
    rd(A_STATUS, 32'h2, "c2_status_cleared");
    pix(8'd7, 8'd8, 8'd9);
    pix(8'd100, 8'd50, 8'd25);
    pix(8'd0, 8'd255, 8'd128);
    // Commit coinciding with a DONE clear: the set must win
    @(negedge clk);
    vs = 1'b1;
    bus.rx_dval = 1'b1; bus.rx_addr = A_STATUS; bus.rx_data = 32'h1;
    @(negedge clk);
    vs = 1'b0; bus.rx_dval = 1'b0;
    rd(A_STATUS, 32'h3, "c2_done_set_wins");
    rd(A_FRAME, 32'd3, "c2_frame");
    rd(A_SUMG, 32'd313, "c2_sum_g");
    rd(A_MIN, pk(0, 8, 9), "c2_min");
    rd(A_MAX, pk(100, 255, 128), "c2_max");
    // Empty frame, read in the commit cycle sees the previous frame
    @(negedge clk);
    vs = 1'b1;
    bus.tx_req = 1'b1; bus.tx_addr = A_PIX;
    exp_q.push_back('{"c3_read_precommit", 32'd3});
    @(negedge clk);
    vs = 1'b0; bus.tx_req = 1'b0;
    rd(A_PIX, 32'd0, "c3_pix_empty");
    rd(A_MIN, 32'd0, "c3_min_empty");
    rd(A_MAX, 32'd0, "c3_max_empty");
    rd(A_FRAME, 32'd4, "c3_frame");

    // Saturation of SUM_R
    @(negedge clk);
    force dut.u_accum.sum_r_q = 32'hFFFF_FF00;
    @(negedge clk);
    release dut.u_accum.sum_r_q;
    pix(8'd255, 8'd1, 8'd1);
    pix(8'd255, 8'd1, 8'd1);
    pix(8'd255, 8'd1, 8'd1);
    vs_pulse();
    rd(A_SUMR, 32'hFFFF_FFFF, "sat_sum_r");
    rd(A_PIX, 32'd3, "sat_pix");
    rd(A_FRAME, 32'd5, "sat_frame");

    // Disable mid-frame: no commit, results retained
    wr(A_STATUS, 32'h1);
    pix(8'd9, 8'd9, 8'd9);
    pix(8'd8, 8'd8, 8'd8);
    wr(A_CTRL, 32'h0);
    idle(2);
    vs_pulse();
    idle(1);
    rd(A_STATUS, 32'h0, "dis_status");
    rd(A_FRAME, 32'd5, "dis_frame");
    rd(A_PIX, 32'd3, "dis_pix");
    rd(A_SUMR, 32'hFFFF_FFFF, "dis_sum_r");

    // Reset in the middle of a running frame
    wr(A_CTRL, 32'h1);
    idle(2);
    vs_pulse();
    pix(8'd50, 8'd60, 8'd70);
    rd(A_STATUS, 32'h2, "pre_rst_busy");
    @(negedge clk);
    de = 1'b1; r = 8'd33;
    rst_n = 1'b0;
    idle(2);
    de = 1'b0;
    rst_n = 1'b1;
    rd(A_CTRL, 32'h0, "rst_ctrl");
    rd(A_STATUS, 32'h0, "rst_status");
    rd(A_FRAME, 32'h0, "rst_frame");
    rd(A_PIX, 32'h0, "rst_pix");
    rd(A_SUMR, 32'h0, "rst_sum_r");
    rd(A_SUMB, 32'h0, "rst_sum_b");
    rd(A_MIN, 32'h0, "rst_min");
    rd(A_MAX, 32'h0, "rst_max");
    rd(A_SCR, 32'h0, "rst_scratch");
    rd(A_ID, 32'h5247_4201, "rst_id");

    idle(3);
    n_cmp++;
    assert (exp_q.size() == 0)
      else begin n_mis++; $error("FAIL pending_reads: observed %0d expected 0", exp_q.size()); end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
